cpu_run_ctrl: RTL and testbench

//  Synthesizable run controller for the pipelined CPU (cpu_pl): sequences CPU reset, gates
//  CPU clock-enable in run/step/halt modes, halts on PC breakpoints, user stop or cycle

---
 rtl/cpu_run_ctrl_pkg.sv | 23 ++
 rtl/run_bp_cmp.sv | 21 ++
 rtl/cpu_run_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the cpu_pl run controller: FSM states and halt causes.
package cpu_run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_HALT = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_DONE = 3'd4,
        S_SCAN = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_USER    = 2'd1,
        CAUSE_BP      = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } cause_e;

    localparam int         SCAN_DEPTH = 32;
    localparam logic [4:0] SCAN_LAST  = 5'(SCAN_DEPTH - 1);

endpackage

// File: rtl/run_bp_cmp.sv
// PC breakpoint comparator bank; bp_hit is purely combinational so the
// controller can mask the CPU enable in the same cycle the PC matches.
module run_bp_cmp #(
    parameter int NUM_BP = 2
) (
    input  logic [NUM_BP-1:0]    bp_en,
    input  logic [NUM_BP*32-1:0] bp_addr,
    input  logic [31:0]          pc_in,
    output logic                 bp_hit
);

    always_comb begin
        bp_hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (pc_in == bp_addr[32*i +: 32])) begin
                bp_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for cpu_pl: reset sequencing, run/step/halt gating, breakpoints,
// timeout and cycle counting. Define RUN_CTRL_SCAN_EN to add the halt-time debug scan.
module cpu_run_ctrl #(
    parameter int RST_CYCLES = 1,
    parameter int TIMEOUT    = 1200,
    parameter int NUM_BP     = 2,
    parameter int CNT_W      = 32,
    parameter int STEP_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 stop,
    input  logic                 step,
    input  logic [STEP_W-1:0]    step_n,
    input  logic [NUM_BP-1:0]    bp_en,
    input  logic [NUM_BP*32-1:0] bp_addr,
    input  logic [31:0]          pc_in,
`ifdef RUN_CTRL_SCAN_EN
    output logic [7:0]           dbg_addr,
    input  logic [31:0]          dbg_data,
    output logic                 dbg_valid,
    output logic [31:0]          dbg_out,
`endif
    output logic                 cpu_rst,
    output logic                 cpu_en,
    output logic                 halted,
    output logic [1:0]           halt_cause,
    output logic [CNT_W-1:0]     cycle_cnt
);

    import cpu_run_ctrl_pkg::*;

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e            state_q, state_d, tgt;
    cause_e            cause_q, cause_d;
    logic [RW-1:0]     rst_cnt_q;
    logic [STEP_W-1:0] step_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              bp_sup_q;
    logic              bp_hit;
    logic              act, to_hit, bp_evt, stop_evt, en, step_last, enter;

`ifdef RUN_CTRL_SCAN_EN
    logic [4:0]  scan_q;
    state_e      ret_q;
    logic        dbg_valid_q;
    logic [31:0] dbg_out_q;
`endif

    run_bp_cmp #(.NUM_BP(NUM_BP)) u_bp (
        .bp_en   (bp_en),
        .bp_addr (bp_addr),
        .pc_in   (pc_in),
        .bp_hit  (bp_hit)
    );

    // Halt events are resolved before cpu_en so the halting cycle never advances.
    always_comb begin
        act       = (state_q == S_RUN) || (state_q == S_STEP);
        to_hit    = act && (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
        bp_evt    = act && bp_hit && !bp_sup_q;
        stop_evt  = act && stop;
        en        = act && !to_hit && !bp_evt && !stop_evt;
        step_last = (state_q == S_STEP) && en && (step_q == STEP_W'(1));
        tgt       = S_HALT;
        enter     = 1'b0;
        state_d   = state_q;
        cause_d   = cause_q;
        unique case (state_q)
            S_RST: begin
                if (rst_cnt_q == RW'(RST_CYCLES - 1)) enter = 1'b1;
            end
            S_HALT: begin
                if (run)       state_d = S_RUN;
                else if (step) state_d = S_STEP;
            end
            S_RUN, S_STEP: begin
                enter = to_hit | bp_evt | stop_evt | step_last;
                if (to_hit) begin
                    tgt     = S_DONE;
                    cause_d = CAUSE_TIMEOUT;
                end else if (bp_evt) begin
                    cause_d = CAUSE_BP;
                end else if (stop_evt) begin
                    cause_d = CAUSE_USER;
                end else if (step_last) begin
                    cause_d = CAUSE_NONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_SCAN: begin
`ifdef RUN_CTRL_SCAN_EN
                if (scan_q == SCAN_LAST) state_d = ret_q;
`else
                state_d = S_HALT;
`endif
            end
            default: state_d = S_RST;
        endcase
        if (enter) begin
`ifdef RUN_CTRL_SCAN_EN
            state_d = S_SCAN;
`else
            state_d = tgt;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RST;
            cause_q   <= CAUSE_NONE;
            rst_cnt_q <= '0;
            step_q    <= '0;
            cnt_q     <= '0;
            bp_sup_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            bp_sup_q <= (state_q == S_HALT) && (run || step);
            if (state_q == S_RST) begin
                rst_cnt_q <= rst_cnt_q + RW'(1);
            end
            if ((state_q == S_HALT) && !run && step) begin
                step_q <= (step_n == '0) ? STEP_W'(1) : step_n;
            end else if ((state_q == S_STEP) && en) begin
                step_q <= step_q - STEP_W'(1);
            end
            if (en && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef RUN_CTRL_SCAN_EN
    // Read data arrives one cycle after its address, so the valid is delayed to match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q      <= '0;
            ret_q       <= S_HALT;
            dbg_valid_q <= 1'b0;
            dbg_out_q   <= '0;
        end else begin
            dbg_valid_q <= (state_q == S_SCAN);
            if (state_q == S_SCAN) begin
                dbg_out_q <= dbg_data;
            end
            if (enter) begin
                ret_q  <= tgt;
                scan_q <= '0;
            end else if (state_q == S_SCAN) begin
                scan_q <= scan_q + 5'd1;
            end
        end
    end

    assign dbg_addr  = {3'b000, scan_q};
    assign dbg_valid = dbg_valid_q;
    assign dbg_out   = dbg_out_q;
`endif

    assign cpu_rst    = (state_q == S_RST);
    assign cpu_en     = en;
    assign halted     = (state_q == S_HALT) || (state_q == S_DONE) ||
                        (state_q == S_SCAN);
    assign halt_cause = cause_q;
    assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a tiny PC model standing in for cpu_pl.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst, run, stop, step;
    logic [15:0] step_n;
    logic [1:0]  bp_en;
    logic [63:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_rst, cpu_en, halted;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_cnt;
    int          errors = 0;
    int          checks = 0;
    int          n;
`ifdef RUN_CTRL_SCAN_EN
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_data, dbg_out;
    logic        dbg_valid;
    assign dbg_data = {24'hC0DE00, dbg_addr};
`endif

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cpu_rst)     pc <= 32'h0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    cpu_run_ctrl #(
        .RST_CYCLES (3),
        .TIMEOUT    (20),
        .NUM_BP     (2),
        .CNT_W      (32),
        .STEP_W     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .stop       (stop),
        .step       (step),
        .step_n     (step_n),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc_in      (pc),
`ifdef RUN_CTRL_SCAN_EN
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .dbg_valid  (dbg_valid),
        .dbg_out    (dbg_out),
`endif
        .cpu_rst    (cpu_rst),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .halt_cause (halt_cause),
        .cycle_cnt  (cycle_cnt)
    );

    task automatic clk1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle;
`ifdef RUN_CTRL_SCAN_EN
        int v = 0;
        for (int i = 0; i < 34; i++) begin
            clk1;
            if (dbg_valid) v++;
        end
        chk("scan_pulses", v, 32);
        chk("scan_halted", halted, 1);
`endif
    endtask

    initial begin
        rst = 1; run = 0; stop = 0; step = 0;
        step_n = 0; bp_en = 0; bp_addr = 0;
        repeat (2) clk1;
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cause", halt_cause, 0);
        chk("rst_cnt", cycle_cnt, 0);

        rst = 0; #1;
        chk("rel_e1", cpu_rst, 1);
        clk1;
        chk("rel_e2", cpu_rst, 1);
        clk1;
        chk("rel_e3", cpu_rst, 1);
        clk1;
        chk("rel_done", cpu_rst, 0);
        chk("rel_halted", halted, 1);
        chk("rel_en", cpu_en, 0);
        settle;

        stop = 1; clk1; stop = 0;
        chk("halt_stop_ign", halted, 1);
        chk("halt_stop_cause", halt_cause, 0);

        step_n = 16'd5; step = 1; #1;
        chk("step_en_halt", cpu_en, 0);
        clk1; step = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (halted) break;
            if (cpu_en) n++;
            clk1;
        end
        chk("step5_n", n, 5);
        chk("step5_halted", halted, 1);
        chk("step5_cause", halt_cause, 0);
        chk("step5_cnt", cycle_cnt, 5);
        settle;

        step_n = 16'd0; step = 1;
        clk1; step = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (halted) break;
            if (cpu_en) n++;
            clk1;
        end
        chk("step0_n", n, 1);
        chk("step0_cnt", cycle_cnt, 6);
        settle;

        run = 1; clk1; run = 0;
        chk("mid_running", halted, 0);
        clk1;
        chk("mid_cnt7", cycle_cnt, 7);
        rst = 1; #1;
        chk("mid_cnt0", cycle_cnt, 0);
        chk("mid_cause", halt_cause, 0);
        chk("mid_cpu_rst", cpu_rst, 1);
        chk("mid_cpu_en", cpu_en, 0);
        clk1; rst = 0;
        repeat (3) clk1;
        chk("mid_rehalt", halted, 1);
        settle;

        bp_addr = {32'h0, 32'h10}; bp_en = 2'b01;
        run = 1; clk1; run = 0;
        for (int i = 0; i < 20; i++) begin
            if (halted) break;
            clk1;
        end
        chk("bp_pc", pc, 32'h10);
        chk("bp_cause", halt_cause, 2);
        chk("bp_cnt", cycle_cnt, 4);
        settle;
        run = 1; clk1; run = 0;
        chk("bp_resume_en", cpu_en, 1);
        clk1;
        chk("bp_resume_pc", pc, 32'h14);
        chk("bp_resume_run", halted, 0);
        stop = 1; #1;
        chk("stop_mask", cpu_en, 0);
        clk1; stop = 0;
        chk("stop_halted", halted, 1);
        chk("stop_cause", halt_cause, 1);
        chk("stop_pc", pc, 32'h14);
        chk("stop_cnt", cycle_cnt, 5);
        settle;

        bp_addr = {32'h18, 32'h10}; bp_en = 2'b10;
        run = 1; clk1; run = 0;
        clk1;
        stop = 1; #1;
        chk("bpstop_mask", cpu_en, 0);
        clk1; stop = 0;
        chk("bpstop_halted", halted, 1);
        chk("bpstop_cause", halt_cause, 2);
        chk("bpstop_pc", pc, 32'h18);
        chk("bpstop_cnt", cycle_cnt, 6);
        settle;

        bp_en = 2'b00;
        run = 1; clk1; run = 0;
        for (int i = 0; i < 40; i++) begin
            if (halted) break;
            clk1;
        end
        chk("to_cnt", cycle_cnt, 20);
        chk("to_cause", halt_cause, 3);
        chk("to_halted", halted, 1);
        chk("to_pc", pc, 32'h50);
        settle;
        run = 1; clk1; run = 0; clk1;
        chk("done_run_halted", halted, 1);
        chk("done_run_en", cpu_en, 0);
        step_n = 16'd3; step = 1; clk1; step = 0; clk1;
        chk("done_step_halted", halted, 1);
        chk("done_step_cnt", cycle_cnt, 20);
        chk("done_cause", halt_cause, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
